// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (double-dabble), one input bit per clock.
// Digits and overflow are registered and hold between conversions.
module bin_to_bcd_seq #(
    parameter int WIDTH  = 13,
    parameter int DIGITS = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_bin,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_overflow,
    output logic [3:0]       o_thousands,
    output logic [3:0]       o_hundreds,
    output logic [3:0]       o_tens,
    output logic [3:0]       o_ones
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t          r_state;
    logic [WIDTH-1:0] r_bin_sh;
    logic [BW-1:0]   r_bcd_sh;
    logic [CW-1:0]   r_cnt;
    logic            r_ovf;

    logic [BW-1:0]   w_bcd_adj;
    logic [BW-1:0]   w_bcd_next;

    // A nibble <= 9 plus 3 fits in 4 bits, so the adjust never carries.
    always_comb begin
        w_bcd_adj = r_bcd_sh;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_bcd_sh[4*i +: 4] >= 4'd5)
                w_bcd_adj[4*i +: 4] = r_bcd_sh[4*i +: 4] + 4'd3;
        end
        w_bcd_next = {w_bcd_adj[BW-2:0], r_bin_sh[WIDTH-1]};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_bin_sh    <= '0;
            r_bcd_sh    <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_overflow  <= 1'b0;
            o_thousands <= 4'd0;
            o_hundreds  <= 4'd0;
            o_tens      <= 4'd0;
            o_ones      <= 4'd0;
        end else begin
            case (r_state)
                IDLE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        r_bin_sh <= i_bin;
                        r_bcd_sh <= '0;
                        r_cnt    <= '0;
                        r_ovf    <= (32'(i_bin) > 32'd9999);
                        o_busy   <= 1'b1;
                        r_state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_bcd_sh <= w_bcd_next;
                    r_bin_sh <= {r_bin_sh[WIDTH-2:0], 1'b0};
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        if (r_ovf) begin
                            o_thousands <= 4'd9;
                            o_hundreds  <= 4'd9;
                            o_tens      <= 4'd9;
                            o_ones      <= 4'd9;
                        end else begin
                            o_thousands <= w_bcd_next[15:12];
                            o_hundreds  <= w_bcd_next[11:8];
                            o_tens      <= w_bcd_next[7:4];
                            o_ones      <= w_bcd_next[3:0];
                        end
                        o_overflow <= r_ovf;
                        o_done     <= 1'b1;
                        o_busy     <= 1'b0;
                        r_state    <= IDLE;
                    end else begin
                        o_done <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
